alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing controller between the datapath control unit and the combinational ALU.
- Accepts one operation per start pulse and registers operands.
- Single-cycle opcodes are sent through the external ALU and its 64-bit result is captured.
- mul and div run as internal 32-iteration shift engines. Every result is presented on the 64-bit C bus with a one-cycle done pulse.

Parameters:
- WORD_SIZE, 32, operand width; C is 2*WORD_SIZE. Iteration count equals WORD_SIZE.

Ports:
- clk  in  1  system clock; rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- opcode  in  5  operation code: 00001 add … 01111 not, 00011 mul, 00100 div.
- A  in  WORD_SIZE  operand A / dividend / multiplicand.
- B  in  WORD_SIZE  operand B / divisor / multiplier.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; C valid.
- C  out  2*WORD_SIZE  result register; holds its value until the next done.
- div_by_zero  out  1  set when a div completes with B=0; cleared at the next accepted start.
- alu_opcode  out  5  opcode to the external ALU; 0 outside EXEC.
- alu_a  out  WORD_SIZE  registered A to the ALU (also drives the ALU Y input).
- alu_b  out  WORD_SIZE  registered B to the ALU.
- alu_c  in  2*WORD_SIZE  external ALU result; combinational from alu_*.

Behaviour:
- Reset (clear=1 at a rising edge, any state):
  - State goes to IDLE.
  - busy=0, done=0, C=0, div_by_zero=0, alu_opcode=0, alu_a=0, alu_b=0.
  - Internal counters and accumulators are zeroed; any operation in flight is abandoned with no done.
- States: IDLE, EXEC, MUL_RUN, DIV_RUN, FIX, DONE.
- IDLE, start=1 in cycle t:
  - Latch opcode, A, B; busy=1 from t+1; clear div_by_zero.
  - Opcode 00011 goes to MUL_RUN.
  - Opcode 00100 with B≠0 goes to DIV_RUN.
  - Every other opcode, including div with B=0, goes to EXEC.
- EXEC (cycle t+1):
  - Valid opcodes 00001–01111 except mul/div: alu_opcode=latched opcode, then C<=alu_c at the end of t+1.
  - Undefined opcodes (00000, 10000–11111): C<=0 and the ALU is not driven.
  - div with B=0: C<={A, all-ones} and div_by_zero<=1.
  - Next state is DONE.
- MUL_RUN (t+1..t+32):
  - Signed multiply on magnitudes: shift-add one multiplier bit per cycle.
  - A 6-bit counter counts 0..31; exit to FIX when count=31.
- DIV_RUN (t+1..t+32):
  - Restoring division on magnitudes, one quotient bit per cycle; same counter.
- FIX (t+33): apply signs.
  - mul: 64-bit product negated if A[31]^B[31].
  - div: quotient negated if A[31]^B[31]; remainder takes the sign of A (truncation toward zero).
  - C<={remainder, quotient} for div, or the product for mul. Next state is DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle. Single-cycle ops reach it at t+2; mul/div at t+34.
  - If start=1 in the DONE cycle it is accepted, as in IDLE.
- start while busy=1 is ignored and has no side effect. A/B/opcode changes while busy are ignored.
- Boundary results:
  - -2^31 / -1 gives quotient 0x80000000 (wraps), remainder 0, and div_by_zero=0.
  - -2^31 * -2^31 gives 0x40000000_00000000.

Test Plan:
- Reset, then start add A=5 B=7 (ALU model returns sum) at t -> alu_opcode=00001 at t+1; done at t+2 with C=0x00000000_0000000C; busy high only at t+1.
- mul A=-3 B=7 at t -> busy t+1..t+33; done at t+34 with C=0xFFFFFFFF_FFFFFFEB. Repeat with A=0x80000000 B=0x80000000 -> C=0x40000000_00000000.
- div A=-7 B=2 -> done t+34 with C=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). div A=100 B=7 -> C=0x00000002_0000000E. div A=0x80000000 B=-1 -> C=0x00000000_80000000.
- div A=9 B=0 -> done at t+2 with C=0x00000009_FFFFFFFF and div_by_zero=1. div_by_zero stays 1 until the next start, then clears.
- Start div, pulse start with opcode add at t+5 -> ignored, div result unchanged. Start a new op in the done cycle -> accepted, busy=1 the next cycle.
- Start mul, assert clear at t+10 -> next cycle busy=0, C=0, done never pulses. A subsequent or opcode (01011, A=0xF0 B=0x0F) -> C=0x000000FF at t+2.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequences one op per start: ALU ops finish in 2 cycles, mul/div in 34 via 32-step shift engines.
// start is only taken in IDLE or in the DONE cycle; a start while busy is dropped.
module alu_seq_ctrl #(
  parameter int WORD_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     start,
  input  logic [4:0]               opcode,
  input  logic [WORD_SIZE-1:0]     A,
  input  logic [WORD_SIZE-1:0]     B,
  output logic                     busy,
  output logic                     done,
  output logic [2*WORD_SIZE-1:0]   C,
  output logic                     div_by_zero,
  output logic [4:0]               alu_opcode,
  output logic [WORD_SIZE-1:0]     alu_a,
  output logic [WORD_SIZE-1:0]     alu_b,
  input  logic [2*WORD_SIZE-1:0]   alu_c
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(WORD_SIZE) + 1;
  localparam logic [4:0] OP_MUL = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_RUN,
    S_DIV_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t         state;
  logic [4:0]     opc_q;
  logic [CW-1:0]  cnt;
  // mul: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [2*W-1:0] acc;
  logic [W-1:0]   mag;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] fix_val;
  logic           neg;
  logic           last_iter;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op != 5'd0) && !op[4] && (op != OP_MUL) && (op != OP_DIV);
  endfunction

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};

    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, mag};
    // Remainder stays below the divisor, so bit W of the difference is a clean borrow flag.
    if (div_diff[W])
      div_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
    else
      div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};

    neg = alu_a[W-1] ^ alu_b[W-1];
    if (opc_q == OP_MUL)
      fix_val = neg ? -acc : acc;
    else
      fix_val = {(alu_a[W-1] ? -acc[2*W-1:W] : acc[2*W-1:W]),
                 (neg ? -acc[W-1:0] : acc[W-1:0])};

    last_iter = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      C           <= '0;
      div_by_zero <= 1'b0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      opc_q       <= '0;
      cnt         <= '0;
      acc         <= '0;
      mag         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (start) begin
            opc_q       <= opcode;
            alu_a       <= A;
            alu_b       <= B;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            if (opcode == OP_MUL) begin
              state <= S_MUL_RUN;
              acc   <= {{W{1'b0}}, magnitude(B)};
              mag   <= magnitude(A);
            end else if (opcode == OP_DIV && B != '0) begin
              state <= S_DIV_RUN;
              acc   <= {{W{1'b0}}, magnitude(A)};
              mag   <= magnitude(B);
            end else begin
              state      <= S_EXEC;
              alu_opcode <= is_alu_op(opcode) ? opcode : 5'd0;
            end
          end
        end

        S_EXEC: begin
          alu_opcode <= 5'd0;
          if (is_alu_op(opc_q)) begin
            C <= alu_c;
          end else if (opc_q == OP_DIV) begin
            C           <= {alu_a, {W{1'b1}}};
            div_by_zero <= 1'b1;
          end else begin
            C <= '0;
          end
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        S_MUL_RUN: begin
          acc <= mul_next;
          cnt <= cnt + CW'(1);
          if (last_iter)
            state <= S_FIX;
        end

        S_DIV_RUN: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
          if (last_iter)
            state <= S_FIX;
        end

        S_FIX: begin
          C     <= fix_val;
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: vector table plus hand sequences, results checked through a done-driven scoreboard.
module tb_alu_seq_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clear;
  logic           start;
  logic [4:0]     opcode;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] C;
  logic           div_by_zero;
  logic [4:0]     alu_opcode;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2*W-1:0] alu_c;

  alu_seq_ctrl #(.WORD_SIZE(W)) dut (
    .clk(clk), .clear(clear), .start(start), .opcode(opcode), .A(A), .B(B),
    .busy(busy), .done(done), .C(C), .div_by_zero(div_by_zero),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // External ALU stand-in; an undriven ALU returns junk so stray captures show up.
  always_comb begin
    case (alu_opcode)
      5'd0:    alu_c = 64'hDEAD_BEEF_DEAD_BEEF;
      5'd1:    alu_c = {32'b0, alu_a} + {32'b0, alu_b};
      5'd2:    alu_c = {32'b0, alu_a - alu_b};
      5'd11:   alu_c = {32'b0, alu_a | alu_b};
      5'd15:   alu_c = {32'b0, ~alu_a};
      default: alu_c = {alu_a, alu_b};
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] c;
    logic        dbz;
    int          t0;
    int          lat;
    int          id;
  } sb_t;

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    logic        dbz;
    int          lat;
  } vec_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!clear && done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with C=%h expected no done (cycle %0d)", C, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk($sformatf("op%0d_C", mon_e.id), C, mon_e.c);
        chk($sformatf("op%0d_dbz", mon_e.id), 64'(div_by_zero), 64'(mon_e.dbz));
        chk($sformatf("op%0d_latency", mon_e.id), 64'(cyc - mon_e.t0), 64'(mon_e.lat));
      end
    end
  end

  // Call at a negedge; returns at the following negedge (cycle t+1).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] c, input logic dbz, input int lat, input int id);
    sb_t e;
    start  = 1'b1;
    opcode = op;
    A      = a;
    B      = b;
    e.c = c; e.dbz = dbz; e.t0 = cyc; e.lat = lat; e.id = id;
    sbq.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    opcode = 5'($urandom);
    A      = $urandom;
    B      = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results pending expected 0 (cycle %0d)", sbq.size(), cyc);
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;

    tbl[0]  = '{5'b00011, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 34};
    tbl[1]  = '{5'b00011, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 34};
    tbl[2]  = '{5'b00011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 34};
    tbl[3]  = '{5'b00011, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 34};
    tbl[4]  = '{5'b00011, 32'd0,         32'h0001_2345, 64'h0,                   1'b0, 34};
    tbl[5]  = '{5'b00100, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34};
    tbl[6]  = '{5'b00100, 32'd100,       32'd7,        64'h0000_0002_0000_000E, 1'b0, 34};
    tbl[7]  = '{5'b00100, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34};
    tbl[8]  = '{5'b00100, 32'd5,         32'hFFFF_FFFD, 64'h0000_0002_FFFF_FFFF, 1'b0, 34};
    tbl[9]  = '{5'b00100, 32'hFFFF_FFFB, 32'd3,        64'hFFFF_FFFE_FFFF_FFFF, 1'b0, 34};
    tbl[10] = '{5'b00100, 32'd9,         32'd0,        64'h0000_0009_FFFF_FFFF, 1'b1, 2};
    tbl[11] = '{5'b01011, 32'hF0,        32'h0F,       64'h0000_0000_0000_00FF, 1'b0, 2};
    tbl[12] = '{5'b00010, 32'd10,        32'd3,        64'h0000_0000_0000_0007, 1'b0, 2};
    tbl[13] = '{5'b00000, 32'd1,         32'd2,        64'h0,                   1'b0, 2};
    tbl[14] = '{5'b10101, 32'd1,         32'd2,        64'h0,                   1'b0, 2};
    tbl[15] = '{5'b00101, 32'h11,        32'h22,       64'h0000_0011_0000_0022, 1'b0, 2};
    tbl[16] = '{5'b00100, 32'd7,         32'd7,        64'h0000_0000_0000_0001, 1'b0, 34};

    clear  = 1'b1;
    start  = 1'b0;
    opcode = 5'd0;
    A      = '0;
    B      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_C",      C, 64'd0);
    chk("rst_dbz",    64'(div_by_zero), 64'd0);
    chk("rst_aluop",  64'(alu_opcode), 64'd0);
    chk("rst_alu_a",  64'(alu_a), 64'd0);
    chk("rst_alu_b",  64'(alu_b), 64'd0);
    clear = 1'b0;
    @(negedge clk);

    // add: ALU driven at t+1, done at t+2, busy only at t+1
    issue(5'b00001, 32'd5, 32'd7, 64'h0000_0000_0000_000C, 1'b0, 2, 0);
    chk("add_busy_t1",  64'(busy), 64'd1);
    chk("add_aluop_t1", 64'(alu_opcode), 64'd1);
    chk("add_alua_t1",  64'(alu_a), 64'd5);
    chk("add_alub_t1",  64'(alu_b), 64'd7);
    @(negedge clk);
    chk("add_busy_t2",  64'(busy), 64'd0);
    chk("add_done_t2",  64'(done), 64'd1);
    chk("add_aluop_t2", 64'(alu_opcode), 64'd0);
    @(negedge clk);
    chk("add_done_t3",  64'(done), 64'd0);
    drain();

    for (int i = 0; i < 17; i++) begin
      issue(tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].dbz, tbl[i].lat, 10 + i);
      drain();
    end

    // div_by_zero persists until the next accepted start
    issue(5'b00100, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 1'b1, 2, 40);
    drain();
    repeat (5) @(negedge clk);
    chk("dbz_hold",   64'(div_by_zero), 64'd1);
    chk("dbz_C_hold", C, 64'h0000_0009_FFFF_FFFF);
    issue(5'b00001, 32'd1, 32'd1, 64'h2, 1'b0, 2, 41);
    chk("dbz_clear_t1", 64'(div_by_zero), 64'd0);
    drain();

    // start while busy is ignored
    issue(5'b00100, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 34, 42);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    opcode = 5'b00001;
    A      = 32'd1;
    B      = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_busy", 64'(busy), 64'd1);
    chk("busy_start_alua", 64'(alu_a), 64'd100);
    drain();
    repeat (5) @(negedge clk);

    // new start in the DONE cycle
    issue(5'b00011, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 34, 43);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 64'(done), 64'd1);
    issue(5'b00010, 32'd10, 32'd3, 64'h7, 1'b0, 2, 44);
    chk("b2b_busy_next", 64'(busy), 64'd1);
    chk("b2b_done_next", 64'(done), 64'd0);
    drain();

    // clear mid-mul abandons the op
    start  = 1'b1;
    opcode = 5'b00011;
    A      = 32'd5;
    B      = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy",  64'(busy), 64'd0);
    chk("clr_C",     C, 64'd0);
    chk("clr_done",  64'(done), 64'd0);
    chk("clr_alu_a", 64'(alu_a), 64'd0);
    repeat (40) @(negedge clk);
    issue(5'b01011, 32'hF0, 32'h0F, 64'h0000_0000_0000_00FF, 1'b0, 2, 45);
    drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
